mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (I) and data (D) ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build gives D fixed priority.
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        global_en,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic own_d, pick_d, go, resp;
  assign go = global_en & ~rst & (state == IDLE) & (i_req | d_req);
`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign pick_d = d_req & (~i_req | ~last_d);
  always_ff @(posedge clk or posedge rst)
    if (rst) last_d <= 1'b1;
    else if (go) last_d <= pick_d;
`else
  assign pick_d = d_req;
`endif
  assign i_gnt = go & ~pick_d;
  assign d_gnt = go & pick_d;
  assign mem_en = go;
  assign mem_we = d_gnt & d_we;
  assign mem_addr = i_gnt ? i_addr : d_gnt ? d_addr : '0;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  assign resp = global_en & ~rst & (state == RESP);
  assign i_rvalid = resp & ~own_d;
  assign d_rvalid = resp & own_d;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (global_en)
      case (state)
        IDLE: if (go) begin
          state_nx = mem_we ? RESP : WAIT;
          cnt_nx = 2'(LAT - 1);
        end
        WAIT: begin
          state_nx = cnt == 2'd0 ? RESP : WAIT;
          cnt_nx = cnt == 2'd0 ? 2'd0 : cnt - 2'd1;
        end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      own_d <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (global_en) begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (go) own_d <= pick_d;
      if (state == WAIT && cnt == 2'd0) begin
        if (own_d) d_rdata <= mem_rdata;
        else i_rdata <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1, global_en = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0, errors = 0;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .global_en(global_en),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 16-word memory; read output holds the last read location until the next read access
  logic [31:0] mem [16];
  logic [3:0] rd_idx = '0;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else rd_idx <= mem_addr[5:2];
    end
  assign mem_rdata = mem[rd_idx];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    global_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic en, ir, dr, we, ig_rr, dg_rr, ig_fp, dg_fp;
  } vec_t;
  vec_t vt[9];

  logic m_busy, m_own_d, m_last_d;
  int m_rem;
  logic [31:0] m_data, m_ir, m_dr, ga;
  logic e_go, e_d, e_ig, e_dg, e_resp, i_taken, d_taken;

  initial begin
    logic eig, edg;
    bit got;
    do_reset();
    chk("reset_i_rdata", i_rdata, 0);
    chk("reset_d_rdata", d_rdata, 0);
    chk("reset_rvalid", {i_rvalid, d_rvalid}, 0);
    vt[0] = '{0, 1, 1, 0, 0, 0, 0, 0};
    vt[1] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vt[2] = '{1, 1, 0, 0, 1, 0, 1, 0};
    vt[3] = '{1, 0, 1, 0, 0, 1, 0, 1};
    vt[4] = '{1, 0, 1, 1, 0, 1, 0, 1};
    vt[5] = '{1, 1, 1, 0, 1, 0, 0, 1};
    vt[6] = '{1, 1, 1, 1, 0, 1, 0, 1};
    vt[7] = '{1, 1, 1, 0, 1, 0, 0, 1};
    vt[8] = '{1, 1, 1, 1, 0, 1, 0, 1};
    i_addr = 32'h40;
    d_addr = 32'h80;
    d_wdata = 32'h0BAD_F00D;
    for (int v = 0; v < 9; v++) begin
`ifdef ARB_ROUND_ROBIN_EN
      eig = vt[v].ig_rr;
      edg = vt[v].dg_rr;
`else
      eig = vt[v].ig_fp;
      edg = vt[v].dg_fp;
`endif
      global_en = vt[v].en;
      i_req = vt[v].ir;
      d_req = vt[v].dr;
      d_we = vt[v].we;
      @(negedge clk);
      chk($sformatf("vec%0d_i_gnt", v), i_gnt, eig);
      chk($sformatf("vec%0d_d_gnt", v), d_gnt, edg);
      chk($sformatf("vec%0d_mem_en", v), mem_en, eig | edg);
      chk($sformatf("vec%0d_mem_we", v), mem_we, edg & vt[v].we);
      chk($sformatf("vec%0d_mem_addr", v), mem_addr, eig ? 32'h40 : edg ? 32'h80 : 32'h0);
      step();
      i_req = 1'b0;
      d_req = 1'b0;
      global_en = 1'b1;
      if (eig | edg) begin
        got = 0;
        for (int k = 0; k < LAT + 3 && !got; k++) begin
          @(negedge clk);
          got = i_rvalid | d_rvalid;
          if (got) chk($sformatf("vec%0d_owner", v), {i_rvalid, d_rvalid}, {eig, edg});
          step();
        end
        if (!got) chk($sformatf("vec%0d_rvalid_timeout", v), 0, 1);
      end
    end

    // D write of DEADBEEF to 0x100, then I read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr0_d_gnt", d_gnt, 1);
    chk("wr0_mem_we", mem_we, 1);
    step();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("wr0_d_rvalid", d_rvalid, 1);
    step();
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("rd_i_gnt", i_gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      i_req = 1'b0;
      @(negedge clk);
      chk($sformatf("rd_i_rvalid_c%0d", c), i_rvalid, c == LAT + 1);
    end
    chk("rd_i_rdata", i_rdata, 32'hDEADBEEF);
    step();

    // write acknowledge timing
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_d_gnt", d_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_i_rvalid_c0", i_rvalid, 0);
    step();
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("wr_d_rvalid", d_rvalid, 1);
    chk("wr_i_rvalid_c1", i_rvalid, 0);
    chk("wr_d_rdata_held", d_rdata, 32'h0BAD_F00D);
    step();
    @(negedge clk);
    chk("wr_d_rvalid_once", d_rvalid, 0);
    step();

    // enable freeze during a read: response slips by the frozen cycles
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("frz_i_gnt", i_gnt, 1);
    for (int c = 1; c <= LAT + 3; c++) begin
      step();
      i_req = 1'b0;
      global_en = !(c == 1 || c == 2);
      d_req = (c == 1 || c == 2);
      @(negedge clk);
      chk($sformatf("frz_i_rvalid_c%0d", c), i_rvalid, c == LAT + 3);
      chk($sformatf("frz_mem_en_c%0d", c), mem_en, 0);
    end
    chk("frz_i_rdata", i_rdata, 32'h12345678);
    step();
    d_req = 1'b0; global_en = 1'b1;

    // reset in the middle of a read discards it
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("rst_i_gnt_c0", i_gnt, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs_zero", {i_gnt, d_gnt, mem_en, i_rvalid, d_rvalid}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_regrant", i_gnt, 1);
    step();
    i_req = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      chk($sformatf("rst_rvalid_c%0d", c), i_rvalid, c == LAT + 1);
      step();
    end
    @(negedge clk);
    chk("rst_no_extra_rvalid", {i_rvalid, d_rvalid}, 0);

    // both requesters held high from reset release
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int c = 0; c < 4 * (LAT + 2); c++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("both_i_gnt_c%0d", c), i_gnt, c % (LAT + 2) == 0 && (c / (LAT + 2)) % 2 == 0);
      chk($sformatf("both_d_gnt_c%0d", c), d_gnt, c % (LAT + 2) == 0 && (c / (LAT + 2)) % 2 == 1);
`else
      chk($sformatf("both_i_gnt_c%0d", c), i_gnt, 0);
      chk($sformatf("both_d_gnt_c%0d", c), d_gnt, c % (LAT + 2) == 0);
`endif
      step();
    end

    // randomized traffic against the transaction model
    do_reset();
    m_busy = 0; m_own_d = 0; m_last_d = 1; m_rem = 0;
    m_ir = 0; m_dr = 0; m_data = 0;
    i_taken = 1; d_taken = 1;
    for (int n = 0; n < 600; n++) begin
      if (!i_req || i_taken) begin
        i_req = $urandom_range(0, 1);
        i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!d_req || d_taken) begin
        d_req = $urandom_range(0, 1);
        d_we = $urandom_range(0, 1);
        d_addr = 32'($urandom_range(0, 15)) << 2;
        d_wdata = $urandom;
      end
      global_en = $urandom_range(0, 4) != 0;
      @(negedge clk);
      e_go = !m_busy && global_en && (i_req || d_req);
`ifdef ARB_ROUND_ROBIN_EN
      e_d = d_req && (!i_req || !m_last_d);
`else
      e_d = d_req;
`endif
      e_ig = e_go && !e_d;
      e_dg = e_go && e_d;
      e_resp = m_busy && global_en && m_rem == 0;
      chk("rnd_i_gnt", i_gnt, e_ig);
      chk("rnd_d_gnt", d_gnt, e_dg);
      chk("rnd_mem_en", mem_en, e_go);
      chk("rnd_mem_we", mem_we, e_dg && d_we);
      chk("rnd_mem_addr", mem_addr, e_ig ? i_addr : e_dg ? d_addr : 32'h0);
      chk("rnd_mem_wdata", mem_wdata, e_dg ? d_wdata : 32'h0);
      chk("rnd_i_rvalid", i_rvalid, e_resp && !m_own_d);
      chk("rnd_d_rvalid", d_rvalid, e_resp && m_own_d);
      chk("rnd_i_rdata", i_rdata, m_ir);
      chk("rnd_d_rdata", d_rdata, m_dr);
      if (e_go) begin
        ga = e_d ? d_addr : i_addr;
        m_busy = 1;
        m_own_d = e_d;
        m_last_d = e_d;
        m_rem = (e_d && d_we) ? 0 : LAT;
        m_data = mem[ga[5:2]];
      end else if (m_busy && global_en) begin
        if (m_rem == 0) m_busy = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_own_d) m_dr = m_data;
            else m_ir = m_data;
          end
        end
      end
      i_taken = e_ig;
      d_taken = e_dg;
      step();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
